// File: rtl/keypad_cmd_encoder.sv
// keypad_cmd_encoder
//  Scans a 4x4 active-low matrix keypad, synchronises and debounces the row
//  returns, and turns each accepted key press into a one-cycle code on cmd.
//  Optional auto-repeat while a key stays held: define KEYPAD_AUTOREPEAT_EN
//  (adds the REPEAT_SCANS parameter).
// Ports
//  clock      in   system clock
//  reset      in   asynchronous active-low reset
//  row[3:0]   in   keypad row returns, active-low
//  col[3:0]   out  column drive, active-low, one bit low at a time
//  cmd[3:0]   out  key code while cmd_valid=1, IDLE_CMD otherwise
//  cmd_valid  out  one-cycle strobe for a new command
//  key_held   out  debounced key-down indication
module keypad_cmd_encoder #(
   parameter int unsigned SCAN_DIV       = 4,
   parameter int unsigned DEBOUNCE_SCANS = 3,
`ifdef KEYPAD_AUTOREPEAT_EN
   parameter int unsigned REPEAT_SCANS   = 32,
`endif
   parameter logic [3:0]  IDLE_CMD       = 4'hF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] cmd,
   output logic       cmd_valid,
   output logic       key_held
);

   localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SCANS);
`endif

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2
   } state_e;

   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [1:0]        col_idx_q, col_idx_d;
   logic [3:0]        col_q, col_d;
   logic [3:0]        row_s1_q, row_s2_q;
   logic [15:0]       snap_q, snap_d;
   logic              sample, scan_done;
   logic              hit_any, hit_multi, is_single, is_none;
   logic [3:0]        hit_idx;
   state_e            state_q, state_d;
   logic [3:0]        cand_q, cand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0]  rel_q, rel_d, rel_inc;
   logic              emit;
   logic [3:0]        emit_idx;
   logic [3:0]        cmd_q, cmd_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              key_held_q, key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
   logic [REP_W-1:0]  rep_q, rep_d, rep_inc;
`endif

   // Snapshot bit index is row*4+col; (3,3) has no code.
   function automatic logic [3:0] key_code(input logic [3:0] idx);
      case (idx)
         4'd0:    key_code = 4'h1;
         4'd1:    key_code = 4'h2;
         4'd2:    key_code = 4'h3;
         4'd3:    key_code = 4'hA;
         4'd4:    key_code = 4'h4;
         4'd5:    key_code = 4'h5;
         4'd6:    key_code = 4'h6;
         4'd7:    key_code = 4'hB;
         4'd8:    key_code = 4'h7;
         4'd9:    key_code = 4'h8;
         4'd10:   key_code = 4'h9;
         4'd11:   key_code = 4'hC;
         4'd12:   key_code = 4'hE;
         4'd13:   key_code = 4'h0;
         4'd14:   key_code = 4'hD;
         default: key_code = IDLE_CMD;
      endcase
   endfunction

   // Column walk and per-column row sampling. The synchroniser adds two
   // cycles, so the last slot cycle still sees the current column's rows.
   always_comb begin
      slot_d    = slot_q + SLOT_W'(1);
      col_idx_d = col_idx_q;
      snap_d    = snap_q;
      sample    = (slot_q == SLOT_LAST);
      if (sample) begin
         slot_d    = '0;
         col_idx_d = col_idx_q + 2'd1;
         for (int r = 0; r < 4; r++) begin
            snap_d[r*4 + int'(col_idx_q)] = ~row_s2_q[r];
         end
      end
      col_d     = ~(4'b0001 << col_idx_d);
      scan_done = sample && (col_idx_q == 2'd3);
   end

   // Classify the completed snapshot; the unmapped key (3,3) is ignored.
   always_comb begin
      hit_any   = 1'b0;
      hit_multi = 1'b0;
      hit_idx   = '0;
      for (int i = 0; i < 15; i++) begin
         if (snap_d[i]) begin
            if (hit_any) hit_multi = 1'b1;
            hit_any = 1'b1;
            hit_idx = 4'(i);
         end
      end
      is_single = hit_any && !hit_multi;
      is_none   = !hit_any;
   end

   // Press/release FSM, stepped once per full scan.
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      rel_d    = rel_q;
      emit     = 1'b0;
      emit_idx = cand_q;
      cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      rel_inc  = (rel_q == CNT_MAX) ? rel_q : rel_q + CNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_d    = rep_q;
      rep_inc  = (rep_q == REP_MAX) ? rep_q : rep_q + REP_W'(1);
`endif
      if (scan_done) begin
         unique case (state_q)
            ST_IDLE: begin
               if (is_single) begin
                  cand_d = hit_idx;
                  cnt_d  = CNT_W'(1);
                  if (CNT_W'(1) == CNT_MAX) begin
                     emit     = 1'b1;
                     emit_idx = hit_idx;
                     state_d  = ST_PRESSED;
                     rel_d    = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rep_d    = '0;
`endif
                  end else begin
                     state_d = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (is_single && (hit_idx == cand_q)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     emit    = 1'b1;
                     state_d = ST_PRESSED;
                     rel_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rep_d   = '0;
`endif
                  end
               end else if (is_single) begin
                  cand_d = hit_idx;
                  cnt_d  = CNT_W'(1);
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            ST_PRESSED: begin
               // MULTI blocks release but never re-triggers a press.
               if (is_none) begin
                  rel_d = rel_inc;
                  if (rel_inc == CNT_MAX) begin
                     state_d = ST_IDLE;
                     rel_d   = '0;
                     cnt_d   = '0;
                  end
               end else begin
                  rel_d = '0;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               if (is_single && (hit_idx == cand_q)) begin
                  if (rep_inc == REP_MAX) begin
                     emit  = 1'b1;
                     rep_d = '0;
                  end else begin
                     rep_d = rep_inc;
                  end
               end else begin
                  rep_d = '0;
               end
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
      cmd_valid_d = emit;
      cmd_d       = emit ? key_code(emit_idx) : IDLE_CMD;
      key_held_d  = (state_d == ST_PRESSED);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot_q      <= '0;
         col_idx_q   <= '0;
         col_q       <= 4'b1110;
         row_s1_q    <= 4'hF;
         row_s2_q    <= 4'hF;
         snap_q      <= '0;
         state_q     <= ST_IDLE;
         cand_q      <= '0;
         cnt_q       <= '0;
         rel_q       <= '0;
         cmd_q       <= IDLE_CMD;
         cmd_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         slot_q      <= slot_d;
         col_idx_q   <= col_idx_d;
         col_q       <= col_d;
         row_s1_q    <= row;
         row_s2_q    <= row_s1_q;
         snap_q      <= snap_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         rel_q       <= rel_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         key_held_q  <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   assign col       = col_q;
   assign cmd       = cmd_q;
   assign cmd_valid = cmd_valid_q;
   assign key_held  = key_held_q;

endmodule
